multiword_adder_sequencer: RTL and testbench

Sequential front/back stage wrapped around one blocked_carry_lookahead_adder instance. Adds two WORDS*WIDTH-bit operands by issuing one WIDTH-bit chunk per cycle, least significant chunk first. The carry is registered between chunks. This provides wide additions without growing the combinational adder. It sits between the operand source (start handshake) and the result consumer (done pulse).

---
 rtl/multiword_adder_sequencer_if.sv | 34 +++
 rtl/multiword_adder_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_multiword_adder_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/multiword_adder_sequencer_if.sv
// Start/result bundle between the operand source, the multiword adder sequencer and the result consumer.
// iSub exists only when SEQ_SUB_EN is defined.
interface multiword_adder_sequencer_if #(
   parameter int WORDS = 4,
   parameter int WIDTH = 16
);
   logic                   iStart;
   logic [WORDS*WIDTH-1:0] iA;
   logic [WORDS*WIDTH-1:0] iB;
   logic                   iC;
`ifdef SEQ_SUB_EN
   logic                   iSub;
`endif
   logic [WORDS*WIDTH-1:0] oS;
   logic                   oC;
   logic                   oBusy;
   logic                   oDone;

   modport master (
`ifdef SEQ_SUB_EN
      output iSub,
`endif
      output iStart, iA, iB, iC,
      input  oS, oC, oBusy, oDone
   );

   modport slave (
`ifdef SEQ_SUB_EN
      input  iSub,
`endif
      input  iStart, iA, iB, iC,
      output oS, oC, oBusy, oDone
   );
endinterface

// File: rtl/multiword_adder_sequencer.sv
// Wide adder built from one WIDTH-bit blocked carry-lookahead adder, one chunk per cycle, LS chunk first.
// Optional macro SEQ_SUB_EN adds iSub for A-B (oC=1 means no borrow).
//
// state  | meaning
// S_IDLE | waiting for iStart
// S_RUN  | one chunk per cycle, carry held in r_carry
// S_DONE | oDone pulse; iStart here restarts with no bubble

module blocked_carry_lookahead_adder #(
   parameter int WIDTH       = 16,
   parameter int BLOCK_WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c,
   output logic [WIDTH-1:0] o_s,
   output logic             o_c
);
   localparam int NBLK = WIDTH / BLOCK_WIDTH;

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_cin;
   logic [NBLK-1:0]  w_bg;
   logic [NBLK-1:0]  w_bp;
   logic [NBLK:0]    w_bc;
   logic             w_rc;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   always_comb begin
      w_bg  = '0;
      w_bp  = '0;
      w_bc  = '0;
      w_cin = '0;
      w_rc  = 1'b0;
      // block generate/propagate, then lookahead across blocks, then bit carries inside each block
      for (int j = 0; j < NBLK; j++) begin
         w_bp[j] = 1'b1;
         for (int i = 0; i < BLOCK_WIDTH; i++) begin
            w_bg[j] = w_g[j*BLOCK_WIDTH+i] | (w_p[j*BLOCK_WIDTH+i] & w_bg[j]);
            w_bp[j] = w_bp[j] & w_p[j*BLOCK_WIDTH+i];
         end
      end
      w_bc[0] = i_c;
      for (int j = 0; j < NBLK; j++) begin
         w_bc[j+1] = w_bg[j] | (w_bp[j] & w_bc[j]);
      end
      for (int j = 0; j < NBLK; j++) begin
         w_rc = w_bc[j];
         for (int i = 0; i < BLOCK_WIDTH; i++) begin
            w_cin[j*BLOCK_WIDTH+i] = w_rc;
            w_rc = w_g[j*BLOCK_WIDTH+i] | (w_p[j*BLOCK_WIDTH+i] & w_rc);
         end
      end
   end

   assign o_s = w_p ^ w_cin;
   assign o_c = w_bc[NBLK];
endmodule

module multiword_adder_sequencer #(
   parameter int WORDS       = 4,
   parameter int WIDTH       = 16,
   parameter int BLOCK_WIDTH = 4
) (
   input  logic                          iClk,
   input  logic                          iRst_n,
   multiword_adder_sequencer_if.slave    bus
);
   localparam int N  = WORDS * WIDTH;
   localparam int CW = $clog2(WORDS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic [N-1:0]     r_s;
   logic             r_carry;
   logic             r_c;
   logic             w_accept;
   logic             w_last;
   logic [N-1:0]     w_b_in;
   logic             w_cin0;
   logic [WIDTH-1:0] w_a_chunk;
   logic [WIDTH-1:0] w_b_chunk;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;

   // subtraction folds into capture: store ~B and force the first carry to 1
`ifdef SEQ_SUB_EN
   assign w_b_in = bus.iSub ? ~bus.iB : bus.iB;
   assign w_cin0 = bus.iSub ? 1'b1 : bus.iC;
`else
   assign w_b_in = bus.iB;
   assign w_cin0 = bus.iC;
`endif

   assign w_last = (r_cnt == CW'(WORDS-1));

   always_comb begin
      w_a_chunk = '0;
      w_b_chunk = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (r_cnt == CW'(k)) begin
            w_a_chunk = r_a[k*WIDTH +: WIDTH];
            w_b_chunk = r_b[k*WIDTH +: WIDTH];
         end
      end
   end

   blocked_carry_lookahead_adder #(
      .WIDTH      (WIDTH),
      .BLOCK_WIDTH(BLOCK_WIDTH)
   ) u_adder (
      .i_a(w_a_chunk),
      .i_b(w_b_chunk),
      .i_c(r_carry),
      .o_s(w_sum),
      .o_c(w_cout)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.iStart) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
            if (bus.iStart) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_c     <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.iA;
         r_b     <= w_b_in;
         r_carry <= w_cin0;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         for (int k = 0; k < WORDS; k++) begin
            if (r_cnt == CW'(k)) r_s[k*WIDTH +: WIDTH] <= w_sum;
         end
         r_carry <= w_cout;
         if (w_last) begin
            r_c   <= w_cout;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.oS    = r_s;
   assign bus.oC    = r_c;
   assign bus.oBusy = (r_state == S_RUN);
   assign bus.oDone = (r_state == S_DONE);
endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Self-checking bench for multiword_adder_sequencer: directed cases plus random operands against an arithmetic model.
module tb_multiword_adder_sequencer;
   localparam int WORDS = 4;
   localparam int WIDTH = 16;
   localparam int BLOCK_WIDTH = 4;
   localparam int N = WORDS * WIDTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   multiword_adder_sequencer_if #(.WORDS(WORDS), .WIDTH(WIDTH)) bus ();

   multiword_adder_sequencer #(
      .WORDS(WORDS), .WIDTH(WIDTH), .BLOCK_WIDTH(BLOCK_WIDTH)
   ) dut (
      .iClk  (clk),
      .iRst_n(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic c, input logic sub);
      logic [N:0] r;
      if (sub) begin
         r[N-1:0] = a - b;
         r[N]     = (a >= b);
      end else begin
         r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [N:0] obs, input logic [N:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic sub);
      bus.iA = a;
      bus.iB = b;
      bus.iC = c;
`ifdef SEQ_SUB_EN
      bus.iSub = sub;
`else
      if (sub) $display("note: subtraction requested in add-only build");
`endif
      bus.iStart = 1'b1;
      tick();
      bus.iStart = 1'b0;
   endtask

   task automatic wait_done(output int n, output int busy_n);
      n = 0;
      busy_n = bus.oBusy ? 1 : 0;
      while (!bus.oDone && n < WORDS + 6) begin
         tick();
         n++;
         if (bus.oBusy) busy_n++;
      end
   endtask

   task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c, input logic sub);
      int n, bn;
      logic [N:0] e;
      e = ref_sum(a, b, c, sub);
      start_op(a, b, c, sub);
      wait_done(n, bn);
      chk({tag, "_latency"}, (N+1)'(n), (N+1)'(WORDS));
      chk({tag, "_busy_cycles"}, (N+1)'(bn), (N+1)'(WORDS));
      chk({tag, "_oS"}, {1'b0, bus.oS}, {1'b0, e[N-1:0]});
      chk({tag, "_oC"}, (N+1)'(bus.oC), (N+1)'(e[N]));
   endtask

   initial begin
      int n, bn, dn;
      logic [N-1:0] a, b;
      logic c, s;
      logic [N:0] e;

      bus.iStart = 1'b1;
      bus.iA = {$urandom, $urandom};
      bus.iB = {$urandom, $urandom};
      bus.iC = 1'b1;
`ifdef SEQ_SUB_EN
      bus.iSub = 1'b0;
`endif
      // reset held with iStart asserted
      repeat (3) tick();
      chk("rst_oS", {1'b0, bus.oS}, '0);
      chk("rst_oC", (N+1)'(bus.oC), '0);
      chk("rst_busy", (N+1)'(bus.oBusy), '0);
      chk("rst_done", (N+1)'(bus.oDone), '0);
      bus.iStart = 1'b0;
      rst_n = 1'b1;
      dn = 0; bn = 0;
      repeat (3) begin
         tick();
         if (bus.oDone) dn++;
         if (bus.oBusy) bn++;
      end
      chk("idle_no_done", (N+1)'(dn), '0);
      chk("idle_no_busy", (N+1)'(bn), '0);

      // full carry ripple
      do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
      chk("ripple_const_oS", {1'b0, bus.oS}, '0);
      chk("ripple_const_oC", (N+1)'(bus.oC), (N+1)'(1));
      tick();
      chk("done_one_cycle", (N+1)'(bus.oDone), '0);
      chk("idle_after_done", (N+1)'(bus.oBusy), '0);

      // carry across two chunk boundaries
      do_op("mixed", 64'h0001_8000_FFFF_1234, 64'h0000_8000_0001_0001, 1'b0, 1'b0);
      chk("mixed_const_oS", {1'b0, bus.oS}, {1'b0, 64'h0002_0001_0000_1235});
      repeat (2) tick();
      chk("hold_oS", {1'b0, bus.oS}, {1'b0, 64'h0002_0001_0000_1235});

      // back-to-back: start during DONE
      do_op("b2b_first", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
      start_op(64'd5, 64'd7, 1'b0, 1'b0);
      chk("b2b_no_idle_busy", (N+1)'(bus.oBusy), (N+1)'(1));
      chk("b2b_no_idle_done", (N+1)'(bus.oDone), '0);
      wait_done(n, bn);
      chk("b2b_gap", (N+1)'(n + 1), (N+1)'(WORDS + 1));
      chk("b2b_oS", {1'b0, bus.oS}, (N+1)'(12));
      chk("b2b_oC", (N+1)'(bus.oC), '0);

      // iStart during RUN is ignored
      tick();
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      e = ref_sum(a, b, 1'b0, 1'b0);
      start_op(a, b, 1'b0, 1'b0);
      bus.iA = ~a; bus.iB = 64'h1; bus.iC = 1'b1; bus.iStart = 1'b1;
      repeat (2) tick();
      bus.iStart = 1'b0;
      wait_done(n, bn);
      chk("run_ignore_latency", (N+1)'(n), (N+1)'(WORDS - 2));
      chk("run_ignore_oS", {1'b0, bus.oS}, {1'b0, e[N-1:0]});
      chk("run_ignore_oC", (N+1)'(bus.oC), (N+1)'(e[N]));
      tick();

      // reset at counter=2 aborts
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_oS", {1'b0, bus.oS}, '0);
      chk("abort_oC", (N+1)'(bus.oC), '0);
      chk("abort_busy", (N+1)'(bus.oBusy), '0);
      chk("abort_done", (N+1)'(bus.oDone), '0);
      tick();
      rst_n = 1'b1;
      dn = 0;
      repeat (WORDS + 3) begin
         tick();
         if (bus.oDone) dn++;
      end
      chk("abort_no_done", (N+1)'(dn), '0);

`ifdef SEQ_SUB_EN
      do_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1);
      chk("sub_neg_const", {bus.oC, bus.oS}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      do_op("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1);
      chk("sub_pos_const", {bus.oC, bus.oS}, {1'b1, 64'd2});
      do_op("sub_off", 64'h0001_8000_FFFF_1234, 64'h0000_8000_0001_0001, 1'b0, 1'b0);
      chk("sub_off_const", {bus.oC, bus.oS}, {1'b0, 64'h0002_0001_0000_1235});
`endif

      // random operands, sometimes back-to-back, sometimes with idle gaps
      for (int i = 0; i < 24; i++) begin
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
         c = 1'($urandom_range(0, 1));
`ifdef SEQ_SUB_EN
         s = 1'($urandom_range(0, 1));
`else
         s = 1'b0;
`endif
         do_op("rand", a, b, c, s);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
